l2_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single L2 cache port between the L1 I-cache and the L1 D-cache miss/writeback interfaces.
- Grants one requester at a time and latches its address and write line at grant.
- Holds the L2 command stable until l2_resp, then routes the response back to the granted requester.
- Provides saturating per-requester grant counters for performance bring-up.

---
 rtl/l2_rr_arbiter_pkg.sv | 25 ++
 rtl/l2_rr_arbiter_rr_pick.sv | 24 ++
 rtl/l2_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_l2_rr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_rr_arbiter_pkg.sv
// Shared types for the L2 round-robin arbiter: FSM states, requester
// identities and the encoding of the latched L2 operation.
package l2_arb_types;

  // Arbiter FSM. RELEASE is a one-cycle gap after every transaction so that
  // a requester's stale level request is not granted a second time.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Identity of a requester. It is used both for the round-robin winner and
  // for the side that won most recently.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  // Encoding of the L2 operation latched at grant.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage : l2_arb_types

// File: rtl/l2_rr_arbiter_rr_pick.sv
// Two-way round-robin pick. A lone requester always wins. On a tie the side
// that did not win last time wins.
module rr_pick
  import l2_arb_types::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  requester_t last_winner,
  output requester_t winner,
  output logic       valid
);

  // Select the winner from the current requests and the previous winner.
  always_comb begin
    valid  = req_i | req_d;
    winner = REQ_I;
    if (req_i && req_d) begin
      winner = (last_winner == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      winner = REQ_D;
    end
  end

endmodule : rr_pick

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter that shares the single L2 port between the L1 I-cache
// (line reads) and the L1 D-cache (line reads and writebacks). The address,
// write line and operation are latched at grant, so requester inputs may
// change freely while L2 is busy. The response is steered back to the side
// that owns the transaction.
module l2_rr_arbiter
  import l2_arb_types::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int DATA_FIRST = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  // L2 port
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  // Grant counters
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  // The reset value of last_winner is the non-preferred side, so the
  // preferred side wins the first tie after reset.
  localparam requester_t LAST_WINNER_RST = (DATA_FIRST != 0) ? REQ_I : REQ_D;

  arb_state_t        state_reg, state_next;
  requester_t        last_winner_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic              op_reg;
  logic [CNT_W-1:0]  grant_cnt_reg [2];

  logic              req_i;
  logic              req_d;
  requester_t        pick_winner;
  logic              pick_valid;
  logic              grant;
  logic              busy;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  rr_pick u_rr_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_winner (last_winner_reg),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  // Arbitration happens only in IDLE. RELEASE deliberately ignores requests.
  assign grant = (state_reg == IDLE) && pick_valid;

  // Next-state logic. l2_resp outside BUSY_x has no effect.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = (pick_winner == REQ_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (l2_resp) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. An asynchronous reset abandons any in-flight L2 transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the command and update round-robin history at grant.
  // d_read together with d_write is treated as a writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner_reg <= LAST_WINNER_RST;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      op_reg          <= OP_READ;
    end else if (grant) begin
      last_winner_reg <= pick_winner;
      if (pick_winner == REQ_D) begin
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
        op_reg    <= d_write ? OP_WRITE : OP_READ;
      end else begin
        addr_reg  <= i_addr;
        wdata_reg <= '0;
        op_reg    <= OP_READ;
      end
    end
  end

  // Per-requester saturating grant counters. Index 0 is I, index 1 is D.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
      localparam requester_t SIDE = (gi == 0) ? REQ_I : REQ_D;

      // Count grants to this side and hold at all-ones.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          grant_cnt_reg[gi] <= '0;
        end else if (grant && (pick_winner == SIDE) && (grant_cnt_reg[gi] != '1)) begin
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign i_grants = grant_cnt_reg[0];
  assign d_grants = grant_cnt_reg[1];

  // Commands come from registered state and op only, so they first appear
  // the cycle after grant. They drop as soon as the FSM leaves BUSY_x.
  assign busy     = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  assign l2_read  = busy && (op_reg == OP_READ);
  assign l2_write = busy && (op_reg == OP_WRITE);
  assign l2_addr  = addr_reg;
  assign l2_wdata = wdata_reg;

  // Steer the completion combinationally to the owning side.
  // The read data is broadcast to both sides. It is qualified by the resp strobes.
  assign i_resp  = (state_reg == BUSY_I) && l2_resp;
  assign d_resp  = (state_reg == BUSY_D) && l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule : l2_rr_arbiter

// File: tb/tb_l2_rr_arbiter.sv
// Directed testbench for l2_rr_arbiter. It uses a small counter width so that
// saturation can be reached through real grants.
module tb_l2_rr_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read, d_read, d_write, l2_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, l2_rdata;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] i_grants, d_grants;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  l2_rr_arbiter #(.ADDR_W(AW), .LINE_W(LW), .DATA_FIRST(1), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // L2 model: waits (bounded) for a command and records it. It answers lat
  // cycles after the command rises and samples both resp strobes in the
  // response cycle. It returns one cycle later, with the FSM in RELEASE.
  task automatic serve(input int lat, input logic [LW-1:0] rdata,
                       output bit ok, output logic [AW-1:0] addr,
                       output bit rd, output bit wr,
                       output bit iresp, output bit dresp,
                       output logic [LW-1:0] resp_data);
    ok = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
    iresp = 1'b0; dresp = 1'b0; resp_data = '0;
    for (int k = 0; k < 20; k++) begin
      if (l2_read || l2_write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    addr = l2_addr; rd = l2_read; wr = l2_write;
    repeat (lat) tick();
    l2_resp = 1'b1; l2_rdata = rdata;
    #1;
    iresp = i_resp; dresp = d_resp;
    resp_data = i_resp ? i_rdata : d_rdata;
    @(posedge clk);
    #1;
    l2_resp = 1'b0; l2_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_cmds: got rd/wr/iresp/dresp=%b want 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    vectors++;
    if (i_grants !== '0 || d_grants !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got i=%0d d=%0d want 0 0", i_grants, d_grants);
    end
    vectors++;
    if (l2_addr !== '0 || l2_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_latches: got addr=%h wdata=%h want 0", l2_addr, l2_wdata);
    end
    reset_n = 1'b1;
    tick();
    // A stray l2_resp in IDLE must not produce a response.
    l2_resp = 1'b1;
    #1;
    vectors++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_resp_ignored: got iresp=%b dresp=%b want 0 0", i_resp, d_resp);
    end
    tick();
    l2_resp = 1'b0;
    tick();
    vectors++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_grants !== '0) begin
      miscompares++;
      $display("FAIL idle_stays: got rd=%b wr=%b igr=%0d want 0 0 0", l2_read, l2_write, i_grants);
    end
    $display("test_reset done");
  endtask

  task automatic test_i_only();
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    #1;
    vectors++;
    if (l2_read !== 1'b0) begin
      miscompares++;
      $display("FAIL i_only_no_early_cmd: got l2_read=%b want 0", l2_read);
    end
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_addr !== 32'h1000) begin
      miscompares++;
      $display("FAIL i_only_cmd: got rd=%b wr=%b addr=%h want 1 0 00001000", l2_read, l2_write, l2_addr);
    end
    vectors++;
    if (i_grants !== 4'd1 || d_grants !== 4'd0) begin
      miscompares++;
      $display("FAIL i_only_grants: got i=%0d d=%0d want 1 0", i_grants, d_grants);
    end
    repeat (3) tick();
    vectors++;
    if (l2_read !== 1'b1 || i_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL i_only_wait: got rd=%b iresp=%b want 1 0", l2_read, i_resp);
    end
    tick();
    l2_resp = 1'b1; l2_rdata = {32{8'hA5}};
    #1;
    vectors++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {32{8'hA5}}) begin
      miscompares++;
      $display("FAIL i_only_resp: got iresp=%b dresp=%b data=%h want 1 0 a5..a5", i_resp, d_resp, i_rdata);
    end
    @(posedge clk);
    #1;
    l2_resp = 1'b0; l2_rdata = '0; i_read = 1'b0;
    #1;
    vectors++;
    if (i_resp !== 1'b0 || l2_read !== 1'b0) begin
      miscompares++;
      $display("FAIL i_only_release: got iresp=%b rd=%b want 0 0", i_resp, l2_read);
    end
    tick();
    vectors++;
    if (l2_read !== 1'b0 || i_grants !== 4'd1) begin
      miscompares++;
      $display("FAIL i_only_after: got rd=%b igr=%0d want 0 1", l2_read, i_grants);
    end
    $display("test_i_only done");
  endtask

  task automatic test_simultaneous();
    bit ok, rd, wr, ir, dr;
    logic [AW-1:0] a;
    logic [LW-1:0] rdat;
    do_reset();
    i_read = 1'b1; i_addr = 32'h2000;
    d_read = 1'b1; d_addr = 32'h3000;
    serve(2, {8{32'hBEEF_0001}}, ok, a, rd, wr, ir, dr, rdat);
    vectors++;
    if (!ok || a !== 32'h3000 || !rd || wr || !dr || ir || rdat !== {8{32'hBEEF_0001}}) begin
      miscompares++;
      $display("FAIL simul_first: got ok=%b addr=%h rd=%b wr=%b ir=%b dr=%b want 1 00003000 1 0 0 1", ok, a, rd, wr, ir, dr);
    end
    d_read = 1'b0;
    serve(2, {8{32'hBEEF_0002}}, ok, a, rd, wr, ir, dr, rdat);
    vectors++;
    if (!ok || a !== 32'h2000 || !ir || dr || rdat !== {8{32'hBEEF_0002}}) begin
      miscompares++;
      $display("FAIL simul_second: got ok=%b addr=%h ir=%b dr=%b want 1 00002000 1 0", ok, a, ir, dr);
    end
    i_read = 1'b0;
    tick();
    vectors++;
    if (i_grants !== 4'd1 || d_grants !== 4'd1) begin
      miscompares++;
      $display("FAIL simul_grants: got i=%0d d=%0d want 1 1", i_grants, d_grants);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_fairness();
    bit ok, rd, wr, ir, dr;
    logic [AW-1:0] a;
    logic [LW-1:0] rdat;
    logic [AW-1:0] exp_a;
    do_reset();
    i_read = 1'b1; i_addr = 32'h2000;
    d_read = 1'b1; d_addr = 32'h3000;
    for (int t = 0; t < 6; t++) begin
      exp_a = (t % 2 == 0) ? 32'h3000 : 32'h2000;
      serve(1, {8{32'h0}}, ok, a, rd, wr, ir, dr, rdat);
      vectors++;
      if (!ok || a !== exp_a || dr !== (t % 2 == 0) || ir !== (t % 2 == 1)) begin
        miscompares++;
        $display("FAIL fair_grant%0d: got ok=%b addr=%h ir=%b dr=%b want addr=%h", t, ok, a, ir, dr, exp_a);
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
    vectors++;
    if (i_grants !== 4'd3 || d_grants !== 4'd3) begin
      miscompares++;
      $display("FAIL fair_counts: got i=%0d d=%0d want 3 3", i_grants, d_grants);
    end
    $display("test_fairness done");
  endtask

  task automatic test_writeback();
    do_reset();
    d_write = 1'b1; d_read = 1'b1;
    d_addr = 32'h4000; d_wdata = {8{32'h1234_5678}};
    tick();
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 32'h4000 || l2_wdata !== {8{32'h1234_5678}}) begin
      miscompares++;
      $display("FAIL wb_cmd: got wr=%b rd=%b addr=%h wdata=%h", l2_write, l2_read, l2_addr, l2_wdata);
    end
    d_addr = '1; d_wdata = '1;
    repeat (2) tick();
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 32'h4000 || l2_wdata !== {8{32'h1234_5678}}) begin
      miscompares++;
      $display("FAIL wb_held: got wr=%b rd=%b addr=%h wdata=%h", l2_write, l2_read, l2_addr, l2_wdata);
    end
    l2_resp = 1'b1;
    #1;
    vectors++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL wb_resp: got dresp=%b iresp=%b want 1 0", d_resp, i_resp);
    end
    @(posedge clk);
    #1;
    l2_resp = 1'b0; d_write = 1'b0; d_read = 1'b0;
    #1;
    vectors++;
    if (l2_write !== 1'b0 || d_resp !== 1'b0 || d_grants !== 4'd1) begin
      miscompares++;
      $display("FAIL wb_done: got wr=%b dresp=%b dgr=%0d want 0 0 1", l2_write, d_resp, d_grants);
    end
    tick();
    $display("test_writeback done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_read = 1'b1; d_addr = 32'h5000; i_addr = 32'h6000;
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_addr !== 32'h5000) begin
      miscompares++;
      $display("FAIL rmid_busy: got rd=%b addr=%h want 1 00005000", l2_read, l2_addr);
    end
    tick();
    l2_resp = 1'b1;
    #1;
    vectors++;
    if (d_resp !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_pre_resp: got dresp=%b want 1", d_resp);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0 || d_resp !== 1'b0 || d_grants !== '0 || l2_addr !== '0) begin
      miscompares++;
      $display("FAIL rmid_async: got rd=%b wr=%b dresp=%b dgr=%0d addr=%h want all 0", l2_read, l2_write, d_resp, d_grants, l2_addr);
    end
    l2_resp = 1'b0; d_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1; i_read = 1'b1;
    tick();
    vectors++;
    if (l2_read !== 1'b1 || l2_addr !== 32'h6000 || i_grants !== 4'd1 || d_grants !== 4'd0) begin
      miscompares++;
      $display("FAIL rmid_after: got rd=%b addr=%h igr=%0d dgr=%0d want 1 00006000 1 0", l2_read, l2_addr, i_grants, d_grants);
    end
    l2_resp = 1'b1;
    #1;
    vectors++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_after_resp: got iresp=%b dresp=%b want 1 0", i_resp, d_resp);
    end
    @(posedge clk);
    #1;
    l2_resp = 1'b0; i_read = 1'b0;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    bit ok, rd, wr, ir, dr, all_ok;
    logic [AW-1:0] a;
    logic [LW-1:0] rdat;
    do_reset();
    all_ok = 1'b1;
    i_read = 1'b1; i_addr = 32'h7000;
    for (int n = 1; n <= 17; n++) begin
      serve(1, {8{32'h0}}, ok, a, rd, wr, ir, dr, rdat);
      all_ok &= ok & ir;
      if (n == 15) begin
        vectors++;
        if (i_grants !== 4'hF) begin
          miscompares++;
          $display("FAIL sat_reach: got i=%0d want 15", i_grants);
        end
      end
    end
    i_read = 1'b0;
    tick();
    vectors++;
    if (!all_ok) begin
      miscompares++;
      $display("FAIL sat_served: got all_ok=%b want 1", all_ok);
    end
    vectors++;
    if (i_grants !== 4'hF || d_grants !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_hold: got i=%0d d=%0d want 15 0", i_grants, d_grants);
    end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_fairness();
    test_writeback();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_l2_rr_arbiter
